axi_lite_arbiter_2to1: RTL
==========================

// Module: axi_lite_arbiter_2to1
// PURPOSE
//   Merges the two AXI4-Lite masters of the CPU, M0 (imem_access_unit, fetch) and M1
//   (dmem_access_unit, load/store), onto one AXI4-Lite slave port (unified memory /
//   peripheral fabric). One transaction in flight at a time, round-robin fairness
//   between masters, response routed back to the granted master only.
// PARAMETERS
//   ADDR_WIDTH   32  address width of AW/AR channels
//   DATA_WIDTH   32  data width of W/R channels (WSTRB = DATA_WIDTH/8)
// PORTS
//   clock        in   1   single clock, all logic rising-edge
//   reset        in   1   synchronous, active-high
//   M0_AXI_*     -    -   full AXI4-Lite slave-side port for master 0 (AW/W/B/AR/R, PROT included)
//   M1_AXI_*     -    -   full AXI4-Lite slave-side port for master 1, same signal set as M0
//   S_AXI_*      -    -   full AXI4-Lite master-side port toward the shared slave
//   grant        out  2   one-hot current owner: 01=M0, 10=M1, 00=idle
//   busy         out  1   1 while any state other than IDLE
// BEHAVIOUR
//   States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; registers owner, aw_done, w_done,
//   last_grant.
//   Request per master: rd_req = ARVALID; wr_req = AWVALID | WVALID.
//   IDLE arbitration:
//   - A master with a request wins.
//   - If both masters request, the master other than last_grant wins.
//   - Winner with both wr_req and rd_req takes the write first.
//   - Arbitration cycle itself issues nothing; the next state is entered on the following edge.
//   - Minimum latency is ARVALID at edge n, then S_AXI_ARVALID at n+1.
//   Forwarding (combinational, owner only):
//   - S_AXI_ARADDR/PROT/VALID and S_AXI_AWADDR/PROT/VALID, WDATA/WSTRB/WVALID are
//     muxed from the owner.
//   - Owner AWREADY/WREADY/ARREADY = S side ready, gated by state.
//   - Non-owner READY/BVALID/RVALID are held 0; RDATA/BRESP/RRESP are driven 0 to the non-owner.
//   WR_REQ:
//   - Forwards AW and W independently.
//   - aw_done/w_done are set on the respective S-side handshake, and AWVALID/WVALID to the
//     slave are masked once done.
//   - Go to WR_RESP when both handshakes are complete (same cycle allowed).
//   WR_RESP:
//   - S_AXI_BREADY = owner BREADY; owner BVALID/BRESP = slave.
//   - On the B handshake: last_grant <= owner, then go to IDLE.
//   RD_REQ: forward AR; go to RD_RESP on the S-side AR handshake.
//   RD_RESP:
//   - Owner RVALID/RDATA/RRESP = slave; S_AXI_RREADY = owner RREADY.
//   - On the R handshake: last_grant <= owner, then go to IDLE.
//   Responses (BRESP/RRESP, incl. SLVERR/DECERR) pass through unmodified.
//   Requests of the waiting master stay pending; the arbiter never drops a VALID, and the
//   master must hold it per AXI.
//   Fairness: under continuous requests from both masters, grants alternate M0,M1,M0,...
//   Reset (sync, any state, including mid-transaction):
//   - State <= IDLE, owner/grant <= 0, aw_done = w_done = 0, last_grant <= M1 (so M0 wins
//     the first tie).
//   - busy = 0; all VALID/READY outputs are 0 in the cycle after the reset edge.
//   - The in-flight transaction is abandoned.
//   Boundaries:
//   - A master deasserting VALID before grant (protocol violation) loses arbitration; the
//     arbiter returns to IDLE without issuing.
//   - Same-cycle response handshake and new request: the new request is arbitrated in the
//     IDLE cycle that follows.
// TESTING
//   1. M0 ARADDR=0x0000_0010 alone; slave returns 0x0000_0013 two cycles after AR
//      -> M0 RDATA=0x0000_0013, RRESP=00, grant=01, M1 sees RVALID=0.
//   2. After reset, M0 AR 0x100 and M1 AR 0x200 in the same cycle -> slave sees 0x100 then
//      0x200; a third tie (M0, M1) -> M0 served first.
//   3. M1 AW=0x0000_0040 three cycles before W=0xCAFE_F00D, WSTRB=0xF -> exactly one
//      slave AW and one W handshake; M1 BVALID with BRESP=00; AWVALID is not reissued.
//   4. M1 issues AW+W and AR together -> write completes (B) before S_AXI_ARVALID rises.
//   5. Slave RRESP=10 to an M1 read -> M1 RRESP=10 unchanged, RDATA passed through.
//   6. Assert reset while in RD_RESP with RVALID pending -> next cycle grant=00, busy=0,
//      all READY/VALID outputs 0; a fresh M0 read then completes normally.

Source files
------------

// File: rtl/axi_lite_arbiter_2to1.sv
// axi_lite_arbiter_2to1: merges two AXI4-Lite masters (M0 fetch, M1 load/store)
// onto one AXI4-Lite slave port, one transaction in flight, round-robin on ties.
// Ports: clock, reset (sync, active-high); M0_AXI_* / M1_AXI_* slave-side ports;
// S_AXI_* master-side port; grant (one-hot owner, 00 idle); busy (not IDLE).
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    // master 0
    input  logic [ADDR_WIDTH-1:0]     M0_AXI_AWADDR,
    input  logic [2:0]                M0_AXI_AWPROT,
    input  logic                      M0_AXI_AWVALID,
    output logic                      M0_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     M0_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   M0_AXI_WSTRB,
    input  logic                      M0_AXI_WVALID,
    output logic                      M0_AXI_WREADY,
    output logic [1:0]                M0_AXI_BRESP,
    output logic                      M0_AXI_BVALID,
    input  logic                      M0_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     M0_AXI_ARADDR,
    input  logic [2:0]                M0_AXI_ARPROT,
    input  logic                      M0_AXI_ARVALID,
    output logic                      M0_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     M0_AXI_RDATA,
    output logic [1:0]                M0_AXI_RRESP,
    output logic                      M0_AXI_RVALID,
    input  logic                      M0_AXI_RREADY,
    // master 1
    input  logic [ADDR_WIDTH-1:0]     M1_AXI_AWADDR,
    input  logic [2:0]                M1_AXI_AWPROT,
    input  logic                      M1_AXI_AWVALID,
    output logic                      M1_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     M1_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   M1_AXI_WSTRB,
    input  logic                      M1_AXI_WVALID,
    output logic                      M1_AXI_WREADY,
    output logic [1:0]                M1_AXI_BRESP,
    output logic                      M1_AXI_BVALID,
    input  logic                      M1_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     M1_AXI_ARADDR,
    input  logic [2:0]                M1_AXI_ARPROT,
    input  logic                      M1_AXI_ARVALID,
    output logic                      M1_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     M1_AXI_RDATA,
    output logic [1:0]                M1_AXI_RRESP,
    output logic                      M1_AXI_RVALID,
    input  logic                      M1_AXI_RREADY,
    // shared slave
    output logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    output logic [2:0]                S_AXI_AWPROT,
    output logic                      S_AXI_AWVALID,
    input  logic                      S_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    output logic                      S_AXI_WVALID,
    input  logic                      S_AXI_WREADY,
    input  logic [1:0]                S_AXI_BRESP,
    input  logic                      S_AXI_BVALID,
    output logic                      S_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    output logic [2:0]                S_AXI_ARPROT,
    output logic                      S_AXI_ARVALID,
    input  logic                      S_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    input  logic [1:0]                S_AXI_RRESP,
    input  logic                      S_AXI_RVALID,
    output logic                      S_AXI_RREADY,
    // status
    output logic [1:0]                grant,
    output logic                      busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;

    logic [2:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    // 0 = M0 was served last, 1 = M1 was served last
    logic       last_grant_q, last_grant_d;

    logic sel_m1;
    logic in_wr_req, in_wr_resp, in_rd_req, in_rd_resp;
    logic own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;
    logic awready_own, wready_own, arready_own, bvalid_own, rvalid_own;
    logic req0_wr, req1_wr, req0, req1, pick_m1, win_wr;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign sel_m1     = owner_q[1];
    assign in_wr_req  = (state_q == ST_WR_REQ);
    assign in_wr_resp = (state_q == ST_WR_RESP);
    assign in_rd_req  = (state_q == ST_RD_REQ);
    assign in_rd_resp = (state_q == ST_RD_RESP);

    assign own_awvalid = sel_m1 ? M1_AXI_AWVALID : M0_AXI_AWVALID;
    assign own_wvalid  = sel_m1 ? M1_AXI_WVALID  : M0_AXI_WVALID;
    assign own_bready  = sel_m1 ? M1_AXI_BREADY  : M0_AXI_BREADY;
    assign own_arvalid = sel_m1 ? M1_AXI_ARVALID : M0_AXI_ARVALID;
    assign own_rready  = sel_m1 ? M1_AXI_RREADY  : M0_AXI_RREADY;

    // Slave-side request forwarding; AW/W masked once their handshake is done
    assign S_AXI_AWADDR  = sel_m1 ? M1_AXI_AWADDR : M0_AXI_AWADDR;
    assign S_AXI_AWPROT  = sel_m1 ? M1_AXI_AWPROT : M0_AXI_AWPROT;
    assign S_AXI_WDATA   = sel_m1 ? M1_AXI_WDATA  : M0_AXI_WDATA;
    assign S_AXI_WSTRB   = sel_m1 ? M1_AXI_WSTRB  : M0_AXI_WSTRB;
    assign S_AXI_ARADDR  = sel_m1 ? M1_AXI_ARADDR : M0_AXI_ARADDR;
    assign S_AXI_ARPROT  = sel_m1 ? M1_AXI_ARPROT : M0_AXI_ARPROT;
    assign S_AXI_AWVALID = in_wr_req & ~aw_done_q & own_awvalid;
    assign S_AXI_WVALID  = in_wr_req & ~w_done_q & own_wvalid;
    assign S_AXI_BREADY  = in_wr_resp & own_bready;
    assign S_AXI_ARVALID = in_rd_req & own_arvalid;
    assign S_AXI_RREADY  = in_rd_resp & own_rready;

    // Master-side returns, only the owner ever sees anything
    assign awready_own = in_wr_req & ~aw_done_q & S_AXI_AWREADY;
    assign wready_own  = in_wr_req & ~w_done_q & S_AXI_WREADY;
    assign arready_own = in_rd_req & S_AXI_ARREADY;
    assign bvalid_own  = in_wr_resp & S_AXI_BVALID;
    assign rvalid_own  = in_rd_resp & S_AXI_RVALID;

    assign M0_AXI_AWREADY = owner_q[0] & awready_own;
    assign M0_AXI_WREADY  = owner_q[0] & wready_own;
    assign M0_AXI_ARREADY = owner_q[0] & arready_own;
    assign M0_AXI_BVALID  = owner_q[0] & bvalid_own;
    assign M0_AXI_RVALID  = owner_q[0] & rvalid_own;
    assign M0_AXI_BRESP   = owner_q[0] ? S_AXI_BRESP : '0;
    assign M0_AXI_RRESP   = owner_q[0] ? S_AXI_RRESP : '0;
    assign M0_AXI_RDATA   = owner_q[0] ? S_AXI_RDATA : '0;

    assign M1_AXI_AWREADY = owner_q[1] & awready_own;
    assign M1_AXI_WREADY  = owner_q[1] & wready_own;
    assign M1_AXI_ARREADY = owner_q[1] & arready_own;
    assign M1_AXI_BVALID  = owner_q[1] & bvalid_own;
    assign M1_AXI_RVALID  = owner_q[1] & rvalid_own;
    assign M1_AXI_BRESP   = owner_q[1] ? S_AXI_BRESP : '0;
    assign M1_AXI_RRESP   = owner_q[1] ? S_AXI_RRESP : '0;
    assign M1_AXI_RDATA   = owner_q[1] ? S_AXI_RDATA : '0;

    assign grant = owner_q;
    assign busy  = (state_q != ST_IDLE);

    assign req0_wr = M0_AXI_AWVALID | M0_AXI_WVALID;
    assign req1_wr = M1_AXI_AWVALID | M1_AXI_WVALID;
    assign req0    = req0_wr | M0_AXI_ARVALID;
    assign req1    = req1_wr | M1_AXI_ARVALID;
    // On a tie the master that was not served last wins
    assign pick_m1 = req1 & (~req0 | ~last_grant_q);
    assign win_wr  = pick_m1 ? req1_wr : req0_wr;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    owner_d = pick_m1 ? 2'b10 : 2'b01;
                    state_d = win_wr ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    state_d   = ST_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else if (~aw_done_q & ~w_done_q &
                             ~own_awvalid & ~own_wvalid) begin
                    // owner withdrew before anything was issued
                    state_d = ST_IDLE;
                    owner_d = 2'b00;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    last_grant_d = owner_q[1];
                    owner_d      = 2'b00;
                    state_d      = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (ar_hs) begin
                    state_d = ST_RD_RESP;
                end else if (~own_arvalid) begin
                    state_d = ST_IDLE;
                    owner_d = 2'b00;
                end
            end
            ST_RD_RESP: begin
                if (r_hs) begin
                    last_grant_d = owner_q[1];
                    owner_d      = 2'b00;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'b00;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
